seq_divider: RTL
================

SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter N, default 16, giving the operand width in bits (N >= 2).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port in_valid, input, 1 bit: the dividend and divisor are presented.
REQ-005 SHALL have port in_ready, output, 1 bit: the block can accept an operation.
REQ-006 SHALL have port dividend, input, N bits, unsigned.
REQ-007 SHALL have port divisor, input, N bits, unsigned.
REQ-008 SHALL have port out_valid, output, 1 bit: the result is presented.
REQ-009 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-010 SHALL have port quotient, output, N bits.
REQ-011 SHALL have port remainder, output, N bits.
REQ-012 SHALL have port div_by_zero, output, 1 bit: flags that the divisor was zero.

Function
REQ-013 SHALL implement an unsigned radix-2 restoring divider with three states: IDLE, BUSY and DONE.
REQ-014 SHALL drive in_ready high only in IDLE; an operation is accepted on a clock edge where in_valid and in_ready are both high.
REQ-015 SHALL, on acceptance, register dividend and divisor, clear the partial remainder (N+1 bits), load the iteration counter with N, and enter BUSY; when the divisor is 0 it SHALL instead enter DONE directly.
REQ-016 SHALL, on each BUSY cycle, do one iteration:
- shift {partial remainder, dividend MSB} left by one;
- compute trial = shifted remainder - divisor;
- if trial is non-negative, keep trial and shift quotient bit 1 in; otherwise keep the shifted remainder and shift 0 in;
- decrement the counter.
REQ-017 SHALL move from BUSY to DONE on the iteration where the counter reaches 0, so that out_valid rises exactly N+1 clock edges after acceptance.
REQ-018 SHALL, for a zero divisor, set quotient to all ones, remainder to the dividend and div_by_zero to 1, with out_valid high one edge after acceptance.
REQ-019 SHALL hold out_valid, quotient, remainder and div_by_zero stable in DONE until out_ready is high at a clock edge, then return to IDLE.
REQ-020 SHALL keep in_ready low while in DONE, including on the cycle out_ready is accepted; a new operation may be accepted no earlier than the following cycle.
REQ-021 SHALL ignore in_valid outside IDLE; the operand inputs need to be stable only in the acceptance cycle.
REQ-022 SHALL keep div_by_zero low for every non-zero divisor.
REQ-023 SHALL guarantee dividend = quotient*divisor + remainder, with remainder < divisor, for every non-zero divisor.

Reset
REQ-024 SHALL, when rst is high at a clock edge, enter IDLE and drive in_ready=1, out_valid=0, quotient=0, remainder=0 and div_by_zero=0 from that edge.
REQ-025 SHALL, if reset occurs during BUSY or DONE, discard the operation in flight and produce no output for it.
REQ-026 SHALL give rst priority over any handshake occurring on the same edge.

Structure
REQ-027 SHALL take its state enum type (IDLE, BUSY, DONE) from the shared package div_pkg; the default width constant SHALL also live in that package.
REQ-028 SHALL place the per-iteration compare/subtract/shift datapath in one combinational sub-module, div_step.
REQ-029 SHALL size the counter as $clog2(N+1) bits.
REQ-030 SHALL use no combinational path from in_valid to in_ready or from out_ready to out_valid.

Verification
REQ-031 SHALL cover, with N=16, 100/7: quotient=14, remainder=2, div_by_zero=0, out_valid rising 17 edges after acceptance.
REQ-032 SHALL cover 0xFFFF/1: quotient=0xFFFF, remainder=0; and 3/7: quotient=0, remainder=3.
REQ-033 SHALL cover 5/0: div_by_zero=1, quotient=0xFFFF, remainder=5, out_valid one edge after acceptance.
REQ-034 SHALL cover holding out_ready low for 5 cycles in DONE: outputs remain stable and in_ready remains 0; then out_ready=1 returns the block to IDLE.
REQ-035 SHALL cover asserting rst in the 8th BUSY cycle: out_valid never rises for that operation; a following 40/6 yields quotient=6, remainder=4.
REQ-036 SHALL cover back-to-back random operands (≥1000) checked against a reference model per REQ-023.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and constants for the sequential divider.
package div_pkg;

   localparam int DIV_N = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift, trial subtract, select.
module div_step #(
   parameter int N = 16
) (
   input  logic [N:0]   rem_i,
   input  logic         msb_i,
   input  logic [N-1:0] divisor_i,
   output logic [N:0]   rem_o,
   output logic         qbit_o
);

   logic [N:0]   shifted;
   logic [N+1:0] trial;

   // one extra bit so the trial sign never aliases with shifted's MSB
   always_comb begin
      shifted = {rem_i[N-1:0], msb_i};
      trial   = {1'b0, shifted} - {2'b00, divisor_i};
      qbit_o  = ~trial[N+1];
      rem_o   = qbit_o ? trial[N:0] : shifted;
   end

endmodule

// File: rtl/seq_divider.sv
// Unsigned radix-2 restoring divider with valid/ready handshakes.
module seq_divider
   import div_pkg::*;
#(
   parameter int N = DIV_N
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] dividend,
   input  logic [N-1:0] divisor,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] quotient,
   output logic [N-1:0] remainder,
   output logic         div_by_zero
);

   localparam int CW = $clog2(N + 1);

   div_state_e   state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [N:0]   rem_q, rem_d;
   logic [N-1:0] quo_q, quo_d;
   logic [N-1:0] dvs_q, dvs_d;
   logic         dbz_q, dbz_d;

   logic [N:0]   step_rem;
   logic         step_qbit;

   div_step #(.N(N)) u_step (
      .rem_i     (rem_q),
      .msb_i     (quo_q[N-1]),
      .divisor_i (dvs_q),
      .rem_o     (step_rem),
      .qbit_o    (step_qbit)
   );

   // quo_q starts as the dividend and fills with quotient bits from the right
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      dvs_d   = dvs_q;
      dbz_d   = dbz_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               if (divisor == '0) begin
                  quo_d   = '1;
                  rem_d   = {1'b0, dividend};
                  dbz_d   = 1'b1;
                  state_d = DONE;
               end else begin
                  quo_d   = dividend;
                  dvs_d   = divisor;
                  rem_d   = '0;
                  cnt_d   = CW'(N);
                  dbz_d   = 1'b0;
                  state_d = BUSY;
               end
            end
         end
         BUSY: begin
            rem_d = step_rem;
            quo_d = {quo_q[N-2:0], step_qbit};
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) state_d = DONE;
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         dvs_q   <= '0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         dvs_q   <= dvs_d;
         dbz_q   <= dbz_d;
      end
   end

   always_comb begin
      in_ready    = (state_q == IDLE);
      out_valid   = (state_q == DONE);
      quotient    = out_valid ? quo_q : '0;
      remainder   = out_valid ? rem_q[N-1:0] : '0;
      div_by_zero = out_valid & dbz_q;
   end

endmodule
